hacd_axi_rd_splitter: RTL
=========================

Name: hacd_axi_rd_splitter

Overview:
- Read-channel stage placed between a crossbar master port (AR/R) and the DDR-side AXI4 slave.
- Splits INCR read bursts that exceed MAX_BEATS beats, or that cross a 4 KB boundary, into legal sub-bursts.
- Merges the returned R beats so the upstream master sees exactly one transaction with a single final rlast.
- Write channels do not pass through this block.

Parameters:
- ADDR_WIDTH, `HACD_AXI4_ADDR_WIDTH, address width.
- DATA_WIDTH, `HACD_AXI4_DATA_WIDTH, data width.
- ID_WIDTH, `HACD_AXI4_ID_WIDTH, ID width; IDs pass through unchanged.
- USER_WIDTH, `HACD_AXI4_USER_WIDTH, aruser/ruser width.
- MAX_BEATS, 16, maximum beats per issued sub-burst; power of two, 1..256.
- TRK_DEPTH, 4, number of outstanding original transactions tracked; power of two.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- s_axi_arid/araddr/arlen/arsize/arburst/arlock/arcache/arprot/arqos/aruser  in  per AXI4  upstream AR payload
- s_axi_arvalid  in  1; s_axi_arready  out  1
- s_axi_rid/rdata/rresp/ruser  out  per AXI4  upstream R payload
- s_axi_rlast  out  1; s_axi_rvalid  out  1; s_axi_rready  in  1
- m_axi_ar*  out  same set as s_axi_ar*  downstream AR payload
- m_axi_arvalid  out  1; m_axi_arready  in  1
- m_axi_r*  in  same set as s_axi_r*  downstream R payload
- m_axi_rvalid  in  1; m_axi_rready  out  1

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous and active-low.
- Reset values: s_axi_arready=0, m_axi_arvalid=0, all ar payload regs=0, tracker FIFO empty, beat/sub counters=0. s_axi_rvalid follows m_axi_rvalid combinationally, so it is 0 whenever the downstream is idle.
- AR FSM states:
  - IDLE: arready=1 iff tracker not full AND (tracker empty OR s_axi_arid == tracked ID). On accept, latch addr, len+1 (9-bit beats_left), size, burst and sideband, then go to ISSUE.
  - ISSUE: present m_axi_arvalid=1. Payload is held stable until m_axi_arready.
  - Next sub-burst: on handshake, beats_left -= sub_beats and addr += sub_beats<<size. If beats_left==0, push the sub-burst count into the tracker and go to IDLE; otherwise stay in ISSUE with the next sub-burst.
- Latency: first m_axi_arvalid appears 1 cycle after the s_axi_ar handshake. Back-to-back sub-bursts issue on consecutive cycles when arready=1.
- Sub-burst sizing:
  - sub_beats = min(beats_left, MAX_BEATS, beats_to_4k); m_axi_arlen = sub_beats-1.
  - beats_to_4k = (4096 - addr[11:0]) >> size, computed in 13 bits.
  - The first sub-burst uses the original (possibly unaligned) address. Later sub-bursts use the address aligned to size.
- FIXED and WRAP bursts are never split: a single pass-through issue, tracker count=1.
- Sub-burst count is held in 9 bits; maximum 256 for len=255, MAX_BEATS=1.
- R path:
  - Combinational pass-through: rdata, rresp, rid, ruser, rvalid pass through; m_axi_rready=s_axi_rready.
  - s_axi_rlast = m_axi_rlast AND (sub_done+1 == tracker head count).
  - On each m_axi_rlast handshake, sub_done increments. When it reaches the head count, the tracker pops and sub_done clears.
- Ordering: the ID rule in IDLE keeps all outstanding entries on one ID, so returns are in order. A new ID stalls until the tracker empties.
- Boundary conditions:
  - Tracker full: arready=0.
  - R beat arriving with tracker empty: protocol error. It is passed through with rlast forced to m_axi_rlast; assertion in simulation.
  - Simultaneous push (AR complete) and pop (last R): the count is unchanged and both take effect.
  - Reset mid-burst: everything is abandoned and returns to IDLE.

Optional Feature:
- Macro HACD_AR_SPLIT_STATS_EN.
- When defined, adds two outputs:
  - stat_split_txn (32 bit): original transactions that needed more than 1 sub-burst.
  - stat_sub_bursts (32 bit): total m_axi_ar handshakes.
- Both counters saturate and are cleared by rst_n.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Decomposition:
- hacd_pkg / hacd_define.vh:
  - AXI burst-type constants (FIXED=2'b00, INCR=2'b01, WRAP=2'b10).
  - 4 KB page constant.
  - Tracker entry typedef {id, sub_count[8:0]}.
- One sub-module, hacd_trk_fifo: synchronous FIFO of depth TRK_DEPTH, with full/empty/count outputs and simultaneous push/pop support.

Test Plan:
1. INCR, addr 0x1000, len 63, size 6 (64 B) -> 4 sub-bursts: arlen 15 at 0x1000, 0x1400, 0x1800, 0x1C00. Upstream sees 64 beats with a single rlast on beat 64.
2. INCR, addr 0x0FC0, len 3, size 6 -> split at 4 KB: arlen 0 at 0x0FC0, then arlen 2 at 0x1000. 4 beats returned, rlast only on the 4th.
3. WRAP, len 15, addr 0x2040 -> single m_ar with identical payload. rlast passes through unchanged.
4. Four INCR len 31 transactions on ID 3, then an AR on ID 5 -> ID 5 arready stays 0 until the final rlast of the 4th ID-3 transaction, then is accepted next cycle.
5. rst_n asserted during ISSUE of the 2nd sub-burst -> m_axi_arvalid=0 immediately (async). After release the tracker is empty and s_axi_arready=1.
6. With HACD_AR_SPLIT_STATS_EN, run scenarios 1+2+3 -> stat_split_txn=2, stat_sub_bursts=7.

Source files
------------

// File: rtl/hacd_pkg.sv
// Shared constants and types for the HACD AXI read splitter.
package hacd_pkg;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] BURST_WRAP  = 2'b10;

    localparam logic [12:0] PAGE_4K = 13'h1000;

    localparam int unsigned SUB_CNT_W = 9;
    typedef logic [SUB_CNT_W-1:0] sub_cnt_t;

    typedef enum logic [0:0] {StIdle, StIssue} ar_state_e;

    // Beats that fit between a size-aligned page offset and the next 4 KB boundary.
    function automatic logic [12:0] beats_to_4k(input logic [11:0] offs, input logic [2:0] size);
        return (PAGE_4K - {1'b0, offs}) >> size;
    endfunction

endpackage

// File: rtl/hacd_trk_fifo.sv
// Synchronous tracker FIFO with simultaneous push/pop; pops from empty and pushes into a
// full FIFO without a concurrent pop are ignored.
module hacd_trk_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop)      count_q <= count_q + CNT_W'(1);
            else if (do_pop && !do_push) count_q <= count_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/hacd_axi_rd_splitter.sv
// AXI4 read-channel splitter: cuts INCR bursts at MAX_BEATS / 4 KB and merges R so the master
// sees one rlast. Optional stats counters under HACD_AR_SPLIT_STATS_EN.
`ifndef HACD_AXI4_ADDR_WIDTH
`define HACD_AXI4_ADDR_WIDTH 32
`endif
`ifndef HACD_AXI4_DATA_WIDTH
`define HACD_AXI4_DATA_WIDTH 64
`endif
`ifndef HACD_AXI4_ID_WIDTH
`define HACD_AXI4_ID_WIDTH 4
`endif
`ifndef HACD_AXI4_USER_WIDTH
`define HACD_AXI4_USER_WIDTH 1
`endif

module hacd_axi_rd_splitter
    import hacd_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = `HACD_AXI4_ADDR_WIDTH,
    parameter int unsigned DATA_WIDTH = `HACD_AXI4_DATA_WIDTH,
    parameter int unsigned ID_WIDTH   = `HACD_AXI4_ID_WIDTH,
    parameter int unsigned USER_WIDTH = `HACD_AXI4_USER_WIDTH,
    parameter int unsigned MAX_BEATS  = 16,
    parameter int unsigned TRK_DEPTH  = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [ID_WIDTH-1:0]   s_axi_arid,
    input  logic [ADDR_WIDTH-1:0] s_axi_araddr,
    input  logic [7:0]            s_axi_arlen,
    input  logic [2:0]            s_axi_arsize,
    input  logic [1:0]            s_axi_arburst,
    input  logic                  s_axi_arlock,
    input  logic [3:0]            s_axi_arcache,
    input  logic [2:0]            s_axi_arprot,
    input  logic [3:0]            s_axi_arqos,
    input  logic [USER_WIDTH-1:0] s_axi_aruser,
    input  logic                  s_axi_arvalid,
    output logic                  s_axi_arready,
    output logic [ID_WIDTH-1:0]   s_axi_rid,
    output logic [DATA_WIDTH-1:0] s_axi_rdata,
    output logic [1:0]            s_axi_rresp,
    output logic [USER_WIDTH-1:0] s_axi_ruser,
    output logic                  s_axi_rlast,
    output logic                  s_axi_rvalid,
    input  logic                  s_axi_rready,
    output logic [ID_WIDTH-1:0]   m_axi_arid,
    output logic [ADDR_WIDTH-1:0] m_axi_araddr,
    output logic [7:0]            m_axi_arlen,
    output logic [2:0]            m_axi_arsize,
    output logic [1:0]            m_axi_arburst,
    output logic                  m_axi_arlock,
    output logic [3:0]            m_axi_arcache,
    output logic [2:0]            m_axi_arprot,
    output logic [3:0]            m_axi_arqos,
    output logic [USER_WIDTH-1:0] m_axi_aruser,
    output logic                  m_axi_arvalid,
    input  logic                  m_axi_arready,
    input  logic [ID_WIDTH-1:0]   m_axi_rid,
    input  logic [DATA_WIDTH-1:0] m_axi_rdata,
    input  logic [1:0]            m_axi_rresp,
    input  logic [USER_WIDTH-1:0] m_axi_ruser,
    input  logic                  m_axi_rlast,
    input  logic                  m_axi_rvalid,
    output logic                  m_axi_rready
`ifdef HACD_AR_SPLIT_STATS_EN
    ,
    output logic [31:0]           stat_split_txn,
    output logic [31:0]           stat_sub_bursts
`endif
);
    localparam logic [8:0] MaxBeats = 9'(MAX_BEATS);
    localparam int unsigned CntW = $clog2(TRK_DEPTH + 1);

    typedef struct packed {
        logic [ID_WIDTH-1:0] id;
        sub_cnt_t            sub_count;
    } trk_entry_t;

    typedef struct packed {
        logic [ID_WIDTH-1:0]   id;
        logic [2:0]            size;
        logic [1:0]            burst;
        logic                  lock;
        logic [3:0]            cache;
        logic [2:0]            prot;
        logic [3:0]            qos;
        logic [USER_WIDTH-1:0] user;
    } ar_side_t;

    ar_state_e             state_q, state_d;
    ar_side_t              side_q, side_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d, addr_align;
    sub_cnt_t              beats_left_q, beats_left_d, sub_cnt_q, sub_cnt_d;
    sub_cnt_t              sub_done_q, sub_done_d, sub_beats;
    logic [12:0]           to_4k;
    logic                  ar_hs, trk_push, trk_pop, trk_full, trk_empty, last_sub, r_last_hs;
    logic [CntW-1:0]       trk_count;
    trk_entry_t            trk_head, trk_wdata;

    hacd_trk_fifo #(
        .DEPTH (TRK_DEPTH),
        .WIDTH ($bits(trk_entry_t))
    ) u_trk_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (trk_push),
        .wdata (trk_wdata),
        .pop   (trk_pop),
        .rdata (trk_head),
        .full  (trk_full),
        .empty (trk_empty),
        .count (trk_count)
    );

    // Only one ID may be outstanding so R returns stay in tracker order.
    assign s_axi_arready = rst_n && (state_q == StIdle) && !trk_full &&
                           ((trk_count == '0) || (s_axi_arid == trk_head.id));

    assign addr_align = addr_q & ~((ADDR_WIDTH'(1) << side_q.size) - ADDR_WIDTH'(1));
    assign to_4k      = beats_to_4k(addr_align[11:0], side_q.size);

    always_comb begin
        sub_beats = beats_left_q;
        if (side_q.burst == BURST_INCR) begin
            if (sub_beats > MaxBeats) sub_beats = MaxBeats;
            if ({4'd0, sub_beats} > to_4k) sub_beats = to_4k[8:0];
        end
    end

    assign m_axi_arvalid = (state_q == StIssue);
    assign m_axi_araddr  = addr_q;
    assign m_axi_arlen   = 8'(sub_beats - 9'd1);
    assign m_axi_arid    = side_q.id;
    assign m_axi_arsize  = side_q.size;
    assign m_axi_arburst = side_q.burst;
    assign m_axi_arlock  = side_q.lock;
    assign m_axi_arcache = side_q.cache;
    assign m_axi_arprot  = side_q.prot;
    assign m_axi_arqos   = side_q.qos;
    assign m_axi_aruser  = side_q.user;

    assign ar_hs               = m_axi_arvalid && m_axi_arready;
    assign trk_wdata.id        = side_q.id;
    assign trk_wdata.sub_count = sub_cnt_q + 9'd1;

    always_comb begin
        state_d      = state_q;
        side_d       = side_q;
        addr_d       = addr_q;
        beats_left_d = beats_left_q;
        sub_cnt_d    = sub_cnt_q;
        trk_push     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (s_axi_arvalid && s_axi_arready) begin
                    side_d       = '{id: s_axi_arid, size: s_axi_arsize, burst: s_axi_arburst,
                                     lock: s_axi_arlock, cache: s_axi_arcache,
                                     prot: s_axi_arprot, qos: s_axi_arqos, user: s_axi_aruser};
                    addr_d       = s_axi_araddr;
                    beats_left_d = {1'b0, s_axi_arlen} + 9'd1;
                    sub_cnt_d    = '0;
                    state_d      = StIssue;
                end
            end
            StIssue: begin
                if (m_axi_arready) begin
                    beats_left_d = beats_left_q - sub_beats;
                    addr_d       = addr_align + (ADDR_WIDTH'(sub_beats) << side_q.size);
                    sub_cnt_d    = sub_cnt_q + 9'd1;
                    if (beats_left_q == sub_beats) begin
                        trk_push = 1'b1;
                        state_d  = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            side_q       <= '0;
            addr_q       <= '0;
            beats_left_q <= '0;
            sub_cnt_q    <= '0;
            sub_done_q   <= '0;
        end else begin
            state_q      <= state_d;
            side_q       <= side_d;
            addr_q       <= addr_d;
            beats_left_q <= beats_left_d;
            sub_cnt_q    <= sub_cnt_d;
            sub_done_q   <= sub_done_d;
        end
    end

    assign s_axi_rvalid = m_axi_rvalid;
    assign s_axi_rid    = m_axi_rid;
    assign s_axi_rdata  = m_axi_rdata;
    assign s_axi_rresp  = m_axi_rresp;
    assign s_axi_ruser  = m_axi_ruser;
    assign m_axi_rready = s_axi_rready;

    assign last_sub    = ((sub_done_q + 9'd1) == trk_head.sub_count);
    assign s_axi_rlast = m_axi_rlast && (trk_empty || last_sub);
    assign r_last_hs   = m_axi_rvalid && s_axi_rready && m_axi_rlast;
    assign trk_pop     = r_last_hs && !trk_empty && last_sub;

    always_comb begin
        sub_done_d = sub_done_q;
        if (r_last_hs && !trk_empty) begin
            sub_done_d = last_sub ? '0 : sub_done_q + 9'd1;
        end
    end

    // R data with nothing tracked means the downstream returned an unrequested burst.
    assert property (@(posedge clk) disable iff (!rst_n)
                     !(m_axi_rvalid && s_axi_rready && trk_empty));

`ifdef HACD_AR_SPLIT_STATS_EN
    logic [31:0] stat_split_q, stat_sub_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_split_q <= '0;
            stat_sub_q   <= '0;
        end else begin
            if (ar_hs && (stat_sub_q != '1)) stat_sub_q <= stat_sub_q + 32'd1;
            if (trk_push && (sub_cnt_q != '0) && (stat_split_q != '1)) begin
                stat_split_q <= stat_split_q + 32'd1;
            end
        end
    end

    assign stat_split_txn  = stat_split_q;
    assign stat_sub_bursts = stat_sub_q;
`else
    logic unused_ar_hs;
    assign unused_ar_hs = ar_hs;
`endif

endmodule
